mux_scan_nto1: RTL and testbench
================================

# mux_scan_nto1

Registered, parametrised N-to-1 multiplexer with a valid/ready output stage and an autonomous round-robin scan mode. In direct mode it selects one of `CHANNELS` input words by `select_bus`. In scan mode an internal counter walks the channels, presenting one sample every `DWELL` cycles. It sits between banks of switch/sensor inputs and a single serial consumer (display driver, UART framer) that needs registered data tagged with its source channel.

## Interface
Parameters:
- `CHANNELS`, default 7: number of input channels, 2..64.
- `WIDTH`, default 1: bits per channel.
- `DWELL`, default 1: cycles between successive scan samples, at least 1.
- `SEL_W`, localparam: `$clog2(CHANNELS)`, minimum 1.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_bus`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `select_bus`  in  SEL_W  channel index, direct mode only.
- `mode`  in  1  0 = direct, 1 = scan.
- `enable`  in  1  gates all new loads and the dwell counter.
- `out`  out  WIDTH  registered selected word.
- `out_channel`  out  SEL_W  index the current `out` was taken from.
- `out_valid`  out  1  `out`/`out_channel` hold an unconsumed sample.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.

## Operation
- Slot free when `!out_valid || out_ready`. A load writes `out`, `out_channel` and sets `out_valid`. Without a load, an accepted sample clears `out_valid`. `out`/`out_channel` hold their values while `out_valid` is low.
- Index ≥ CHANNELS (select value or otherwise): `out` = 0, `out_channel` = the index as given, `out_valid` = 1. No error flag.
- Direct mode: load on every cycle with `enable && slot free`, using `data_bus` and `select_bus` from that cycle.
- Scan mode FSM, states S_IDLE, S_WAIT, S_LOAD:
  - S_IDLE: entered on reset and whenever `mode` is 0. On `mode` = 1: clear `scan_idx` and `dwell_cnt`, go to S_LOAD.
  - S_LOAD: when `enable && slot free`, load channel `scan_idx`. `scan_idx` then advances, wrapping CHANNELS-1 → 0. If DWELL = 1, stay in S_LOAD. Otherwise set `dwell_cnt` = DWELL-1 and go to S_WAIT. If the slot is not free, stall in S_LOAD: index held, no sample dropped.
  - S_WAIT: `dwell_cnt` decrements only while `enable`. At 1 → 0, go to S_LOAD.
  - `mode` falling to 0 returns to S_IDLE on the next edge. Any pending `out_valid` sample is kept until accepted.
- `enable` = 0: no loads, FSM frozen, handshake on the existing sample still completes.
- Simultaneous accept and load in the same cycle: new sample replaces the old, `out_valid` stays 1. Full throughput is one sample per cycle.

## Timing
- Reset (async assert, sync-to-`clk` release inside the block is not required): `out` = 0, `out_channel` = 0, `out_valid` = 0, `scan_idx` = 0, `dwell_cnt` = 0, state S_IDLE.
- Direct latency: 1 cycle from `select_bus`/`data_bus` to `out`.
- Scan: first sample appears 2 cycles after `mode` rises (S_IDLE → S_LOAD → load). Steady-state period is exactly DWELL cycles when `out_ready` is held 1.
- Reset asserted mid-scan or mid-handshake: outputs go to reset values immediately; the in-flight sample is discarded.
- No combinational path from `out_ready` to any output.

## Structure
- Package `mux_pkg`:
  - `MODE_DIRECT` = 1'b0, `MODE_SCAN` = 1'b1.
  - Scan state typedef `scan_state_t` (S_IDLE, S_WAIT, S_LOAD).
  - Function computing SEL_W with minimum 1.
- Sub-module `mux_nto1` (parameters CHANNELS, WIDTH; purely combinational; out-of-range index gives 0), used once for the selected index. All registers, FSM and handshake stay in the top.

## Test plan
- Direct mode, CHANNELS=7, WIDTH=1, `data_bus` = 7'b1010011, `out_ready` = 1, sweep select 0..7 → `out` 1,1,0,0,1,0,1,0 each one cycle later. `out_channel` tracks select; select 7 gives `out` = 0.
- Scan mode, CHANNELS=4, WIDTH=8, DWELL=3, data {8'h44,8'h33,8'h22,8'h11}, ready = 1 → `out` 11,22,33,44,11 every 3 cycles, first 2 cycles after `mode` rises. `out_channel` wraps 3 → 0.
- Backpressure: scan, DWELL=1, `out_ready` = 0 for 5 cycles after first sample → `out` holds channel 0, `out_valid` = 1. On ready, channels 1, 2, ... follow with none skipped.
- `enable` = 0 for 4 cycles mid-S_WAIT → no new sample; period extends by exactly 4 cycles; pending sample still accepted.
- Switch scan → direct with pending sample, then back to scan → pending sample retained until accepted; re-entry restarts at channel 0.
- Assert `resetn` = 0 mid-scan between clock edges → all outputs 0 immediately. After release, no `out_valid` until a load condition occurs.

Source files
------------

// File: rtl/mux_scan_nto1_pkg.sv
// Shared types and helpers for the scanning N-to-1 multiplexer.
`default_nettype none

package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2
  } scan_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_nto1_if.sv
// Input bus, control and valid/ready output stage of mux_scan_nto1.
`default_nettype none

interface mux_scan_nto1_if
  import mux_pkg::*;
#(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 1
) ();

  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_bus;
  logic [SEL_W-1:0]          select_bus;
  logic                      mode;
  logic                      enable;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_channel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output data_bus, select_bus, mode, enable, out_ready,
    input  out, out_channel, out_valid
  );

  modport slave (
    input  data_bus, select_bus, mode, enable, out_ready,
    output out, out_channel, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/mux_scan_nto1_mux.sv
// Combinational N-to-1 word selector; indices past the last channel yield zero.
`default_nettype none

module mux_nto1
  import mux_pkg::*;
#(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] data_bus,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          word
);

  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        word = data_bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_nto1.sv
// Registered N-to-1 mux with valid/ready output and a round-robin scan mode
// that presents one channel every DWELL enabled cycles.
`default_nettype none

module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 1
) (
  input  logic           clk,
  input  logic           resetn,
  mux_scan_nto1_if.slave bus
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam int DW_W  = sel_width(DWELL);
  localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DWELL_RELOAD = DW_W'(DWELL - 1);

  scan_state_t      state, state_nx;
  logic [SEL_W-1:0] scan_idx, scan_idx_nx;
  logic [DW_W-1:0]  dwell_cnt, dwell_cnt_nx;

  logic [WIDTH-1:0] sample;
  logic [SEL_W-1:0] sample_chan;
  logic             sample_valid;

  logic             slot_free;
  logic             load;
  logic [SEL_W-1:0] load_idx;
  logic [WIDTH-1:0] mux_word;

  // Only registered state reaches the outputs, so out_ready never feeds through.
  assign slot_free = !sample_valid || bus.out_ready;

  mux_nto1 #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .SEL_W    (SEL_W)
  ) u_mux (
    .data_bus (bus.data_bus),
    .sel      (load_idx),
    .word     (mux_word)
  );

  always_comb begin
    state_nx     = state;
    scan_idx_nx  = scan_idx;
    dwell_cnt_nx = dwell_cnt;
    load         = 1'b0;
    load_idx     = bus.select_bus;

    if (bus.mode == MODE_DIRECT) begin
      state_nx = S_IDLE;
      load     = bus.enable && slot_free;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            scan_idx_nx  = '0;
            dwell_cnt_nx = '0;
            state_nx     = S_LOAD;
          end
        end
        S_LOAD: begin
          load_idx = scan_idx;
          // A busy slot stalls here with the index held, so nothing is skipped.
          if (bus.enable && slot_free) begin
            load        = 1'b1;
            scan_idx_nx = (scan_idx == LAST_IDX) ? '0 : scan_idx + SEL_W'(1);
            if (DWELL > 1) begin
              dwell_cnt_nx = DWELL_RELOAD;
              state_nx     = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.enable) begin
            dwell_cnt_nx = dwell_cnt - DW_W'(1);
            if (dwell_cnt <= DW_W'(1)) begin
              dwell_cnt_nx = '0;
              state_nx     = S_LOAD;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      scan_idx     <= '0;
      dwell_cnt    <= '0;
      sample       <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      scan_idx  <= scan_idx_nx;
      dwell_cnt <= dwell_cnt_nx;
      if (load) begin
        sample       <= mux_word;
        sample_chan  <= load_idx;
        sample_valid <= 1'b1;
      end else if (sample_valid && bus.out_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  assign bus.out         = sample;
  assign bus.out_channel = sample_chan;
  assign bus.out_valid   = sample_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
// Directed self-checking bench for mux_scan_nto1 in direct, scan and backpressure use.
`default_nettype none

module tb_mux_scan_nto1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_scan_nto1_if #(.CHANNELS(7), .WIDTH(1)) ifa ();
  mux_scan_nto1_if #(.CHANNELS(4), .WIDTH(8)) ifb ();
  mux_scan_nto1_if #(.CHANNELS(4), .WIDTH(8)) ifc ();

  mux_scan_nto1 #(.CHANNELS(7), .WIDTH(1), .DWELL(1)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  mux_scan_nto1 #(.CHANNELS(4), .WIDTH(8), .DWELL(3)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));
  mux_scan_nto1 #(.CHANNELS(4), .WIDTH(8), .DWELL(1)) dut_c (.clk(clk), .resetn(resetn), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (ifa.out !== 1'b0 || ifa.out_channel !== 3'd0 || ifa.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_a out=%0h chan=%0d valid=%0b want 0/0/0", ifa.out, ifa.out_channel, ifa.out_valid);
    end
    checks++;
    if (ifb.out !== 8'h00 || ifb.out_channel !== 2'd0 || ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b out=%0h chan=%0d valid=%0b want 0/0/0", ifb.out, ifb.out_channel, ifb.out_valid);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (ifa.out_valid !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release valid_a=%0b valid_c=%0b want 0", ifa.out_valid, ifc.out_valid);
    end
  endtask

  task automatic test_direct();
    logic [7:0] exp_a;
    exp_a = 8'b0101_0011;
    ifa.data_bus  = 7'b1010011;
    ifa.out_ready = 1'b1;
    ifa.enable    = 1'b1;
    for (int s = 0; s < 8; s++) begin
      ifa.select_bus = 3'(s);
      tick();
      checks++;
      if (ifa.out !== exp_a[s] || ifa.out_channel !== 3'(s) || ifa.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL direct sel=%0d out=%0b chan=%0d valid=%0b want %0b/%0d/1",
                 s, ifa.out, ifa.out_channel, ifa.out_valid, exp_a[s], s);
      end
    end
    ifa.enable = 1'b0;
    tick();
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out !== 1'b0 || ifa.out_channel !== 3'd7) begin
      errors++;
      $display("FAIL direct_drain out=%0b chan=%0d valid=%0b want 0/7/0", ifa.out, ifa.out_channel, ifa.out_valid);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_b [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    ifb.data_bus  = 32'h4433_2211;
    ifb.out_ready = 1'b1;
    ifb.enable    = 1'b1;
    ifb.mode      = 1'b1;
    tick();
    checks++;
    if (ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_first_latency valid=%0b want 0", ifb.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifb.out !== exp_b[i] || ifb.out_channel !== 2'(i % 4) || ifb.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL scan_sample i=%0d out=%0h chan=%0d valid=%0b want %0h/%0d/1",
                 i, ifb.out, ifb.out_channel, ifb.out_valid, exp_b[i], i % 4);
      end
      if (i < 4) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++;
          if (ifb.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_gap i=%0d g=%0d valid=%0b want 0", i, g, ifb.out_valid);
          end
        end
      end
    end
    ifb.enable = 1'b0;
    ifb.mode   = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_enable_stall();
    ifb.out_ready = 1'b0;
    ifb.enable    = 1'b1;
    ifb.mode      = 1'b1;
    repeat (2) tick();
    checks++;
    if (ifb.out !== 8'h11 || ifb.out_channel !== 2'd0 || ifb.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_first out=%0h chan=%0d valid=%0b want 11/0/1", ifb.out, ifb.out_channel, ifb.out_valid);
    end
    tick();
    ifb.enable    = 1'b0;
    ifb.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ifb.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen c=%0d valid=%0b want 0", c, ifb.out_valid);
      end
    end
    ifb.enable = 1'b1;
    tick();
    checks++;
    if (ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume_early valid=%0b want 0", ifb.out_valid);
    end
    tick();
    checks++;
    if (ifb.out !== 8'h22 || ifb.out_channel !== 2'd1 || ifb.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume out=%0h chan=%0d valid=%0b want 22/1/1", ifb.out, ifb.out_channel, ifb.out_valid);
    end
    ifb.enable = 1'b0;
    ifb.mode   = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_mode_switch();
    ifb.out_ready  = 1'b0;
    ifb.enable     = 1'b1;
    ifb.mode       = 1'b1;
    ifb.select_bus = 2'd2;
    repeat (2) tick();
    ifb.mode     = 1'b0;
    ifb.data_bus = 32'h4433_22A0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifb.out !== 8'h11 || ifb.out_channel !== 2'd0 || ifb.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL switch_hold_direct c=%0d out=%0h chan=%0d valid=%0b want 11/0/1",
                 c, ifb.out, ifb.out_channel, ifb.out_valid);
      end
    end
    ifb.mode = 1'b1;
    repeat (2) tick();
    checks++;
    if (ifb.out !== 8'h11 || ifb.out_channel !== 2'd0 || ifb.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL switch_hold_scan out=%0h chan=%0d valid=%0b want 11/0/1", ifb.out, ifb.out_channel, ifb.out_valid);
    end
    ifb.out_ready = 1'b1;
    tick();
    checks++;
    if (ifb.out !== 8'hA0 || ifb.out_channel !== 2'd0 || ifb.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL switch_restart out=%0h chan=%0d valid=%0b want a0/0/1", ifb.out, ifb.out_channel, ifb.out_valid);
    end
    tick();
    checks++;
    if (ifb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL switch_accept valid=%0b want 0", ifb.out_valid);
    end
    ifb.enable   = 1'b0;
    ifb.mode     = 1'b0;
    ifb.data_bus = 32'h4433_2211;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_c [4];
    exp_c = '{8'h22, 8'h33, 8'h44, 8'h11};
    ifc.data_bus  = 32'h4433_2211;
    ifc.out_ready = 1'b1;
    ifc.enable    = 1'b1;
    ifc.mode      = 1'b1;
    repeat (2) tick();
    checks++;
    if (ifc.out !== 8'h11 || ifc.out_channel !== 2'd0 || ifc.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first out=%0h chan=%0d valid=%0b want 11/0/1", ifc.out, ifc.out_channel, ifc.out_valid);
    end
    ifc.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (ifc.out !== 8'h11 || ifc.out_channel !== 2'd0 || ifc.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold c=%0d out=%0h chan=%0d valid=%0b want 11/0/1",
                 c, ifc.out, ifc.out_channel, ifc.out_valid);
      end
    end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifc.out !== exp_c[i] || ifc.out_channel !== 2'((i + 1) % 4) || ifc.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume i=%0d out=%0h chan=%0d valid=%0b want %0h/%0d/1",
                 i, ifc.out, ifc.out_channel, ifc.out_valid, exp_c[i], (i + 1) % 4);
      end
    end
  endtask

  task automatic test_reset_midscan();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ifc.out !== 8'h00 || ifc.out_channel !== 2'd0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset out=%0h chan=%0d valid=%0b want 0/0/0", ifc.out, ifc.out_channel, ifc.out_valid);
    end
    ifc.enable = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ifc.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d valid=%0b want 0", c, ifc.out_valid);
      end
    end
    ifc.enable = 1'b1;
    tick();
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_latency valid=%0b want 0", ifc.out_valid);
    end
    tick();
    checks++;
    if (ifc.out !== 8'h11 || ifc.out_channel !== 2'd0 || ifc.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first out=%0h chan=%0d valid=%0b want 11/0/1", ifc.out, ifc.out_channel, ifc.out_valid);
    end
  endtask

  initial begin
    ifa.data_bus = '0; ifa.select_bus = '0; ifa.mode = 1'b0; ifa.enable = 1'b0; ifa.out_ready = 1'b1;
    ifb.data_bus = '0; ifb.select_bus = '0; ifb.mode = 1'b0; ifb.enable = 1'b0; ifb.out_ready = 1'b1;
    ifc.data_bus = '0; ifc.select_bus = '0; ifc.mode = 1'b0; ifc.enable = 1'b0; ifc.out_ready = 1'b1;
    test_reset();
    test_direct();
    test_scan();
    test_enable_stall();
    test_mode_switch();
    test_backpressure();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
